// File: rtl/uart_fifo_pkg.sv
// Shared types, default widths and pointer-width helper for the UART stream FIFO.
package uart_fifo_pkg;

  typedef enum logic {
    MEM_REGS = 1'b0,
    MEM_BRAM = 1'b1
  } mem_type_e;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefDepth     = 16;

  // One extra bit beyond the index distinguishes full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// 1W1R storage array for the UART stream FIFO; MEM_TYPE selects async (flops) or sync (BRAM) read.
module uart_fifo_mem
  import uart_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned MEM_TYPE   = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  if (MEM_TYPE == 32'(MEM_BRAM)) begin : gen_sync_read
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        rd_data_q <= '0;
      end else if (rd_en_i) begin
        rd_data_q <= mem_q[rd_addr_i];
      end
    end

    assign rd_data_o = rd_data_q;
  end else begin : gen_async_read
    logic unused_sync_read;

    assign unused_sync_read = resetn ^ rd_en_i;
    assign rd_data_o        = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/uart_stream_fifo.sv
// Synchronous FIFO for the UART TX/RX paths: pointer/flag logic, standard or FWFT read, flush.
// Optional sticky overflow/underflow flags are built when UART_FIFO_ERR_EN is defined.
module uart_stream_fifo
  import uart_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DefDataWidth,
  parameter int unsigned DEPTH         = DefDepth,
  parameter int unsigned MEM_TYPE      = 0,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        clear_i,
  input  logic                        wr_en_i,
  input  logic [DATA_WIDTH-1:0]       wr_data_i,
  input  logic                        rd_en_i,
  output logic [DATA_WIDTH-1:0]       rd_data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        almost_full_o,
  output logic                        almost_empty_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        overflow_o,
  output logic                        underflow_o
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  localparam logic [PW-1:0] DepthCnt = PW'(DEPTH);
  localparam logic [PW-1:0] AfullTh  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AemptyTh = PW'(AEMPTY_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_depth_chk
    $error("uart_stream_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if ((FWFT != 0) && (MEM_TYPE == 32'(MEM_BRAM))) begin : gen_fwft_chk
    $error("uart_stream_fifo: FWFT requires MEM_TYPE=MEM_REGS");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH) || (AEMPTY_THRESH > DEPTH - 1))
  begin : gen_thresh_chk
    $error("uart_stream_fifo: almost-full/almost-empty threshold out of range");
  end

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count;
  logic          full, empty;
  logic          wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Status comes only from registered pointers.
  assign count = wptr_q - rptr_q;
  assign full  = (count == DepthCnt);
  assign empty = (count == '0);

  assign wr_acc = wr_en_i && !full && !clear_i;
  assign rd_acc = rd_en_i && !empty && !clear_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PW'(1);
      if (rd_acc) rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .MEM_TYPE   (MEM_TYPE)
  ) u_mem (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wptr_q[AW-1:0]),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rptr_q[AW-1:0]),
    .rd_data_o (mem_rdata)
  );

  // FWFT shows the head directly; BRAM already has a read-enabled output register.
  if ((FWFT != 0) || (MEM_TYPE == 32'(MEM_BRAM))) begin : gen_rd_direct
    assign rd_data_o = mem_rdata;
  end else begin : gen_rd_reg
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
      rd_data_d = rd_data_q;
      if (rd_acc) rd_data_d = mem_rdata;
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        rd_data_q <= '0;
      end else begin
        rd_data_q <= rd_data_d;
      end
    end

    assign rd_data_o = rd_data_q;
  end

`ifdef UART_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A write at full that coincides with an accepted read is not flagged.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en_i && full && !rd_acc) overflow_d = 1'b1;
      if (rd_en_i && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count >= AfullTh);
  assign almost_empty_o = (count <= AemptyTh);
  assign count_o        = count;

endmodule

// File: tb/tb_uart_stream_fifo.sv
// Directed self-checking bench for uart_stream_fifo (standard-read and FWFT instances).
module tb_uart_stream_fifo;

`ifdef UART_FIFO_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;

  logic       clear, wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic       full, empty, afull, aempty, ovf, unf;
  logic [3:0] count;

  logic       f_clear, f_wr_en, f_rd_en;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [3:0] f_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_stream_fifo #(
    .DATA_WIDTH (8), .DEPTH (8), .MEM_TYPE (0), .FWFT (0),
    .AFULL_THRESH (6), .AEMPTY_THRESH (1)
  ) u_dut (
    .clk (clk), .resetn (resetn), .clear_i (clear),
    .wr_en_i (wr_en), .wr_data_i (wr_data), .rd_en_i (rd_en), .rd_data_o (rd_data),
    .full_o (full), .empty_o (empty), .almost_full_o (afull), .almost_empty_o (aempty),
    .count_o (count), .overflow_o (ovf), .underflow_o (unf)
  );

  uart_stream_fifo #(
    .DATA_WIDTH (8), .DEPTH (8), .MEM_TYPE (0), .FWFT (1),
    .AFULL_THRESH (6), .AEMPTY_THRESH (1)
  ) u_fwft (
    .clk (clk), .resetn (resetn), .clear_i (f_clear),
    .wr_en_i (f_wr_en), .wr_data_i (f_wr_data), .rd_en_i (f_rd_en), .rd_data_o (f_rd_data),
    .full_o (f_full), .empty_o (f_empty), .almost_full_o (f_afull),
    .almost_empty_o (f_aempty), .count_o (f_count), .overflow_o (f_ovf), .underflow_o (f_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_aempty"}, 32'(aempty), 32'd1);
    chk({tag, "_afull"}, 32'(afull), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_unf"}, 32'(unf), 32'd0);
  endtask

  initial begin
    clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    f_clear = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = 8'h00;

    // Reset
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    chk_reset_state("rst");
    chk("fwft_rst_empty", 32'(f_empty), 32'd1);

    // FWFT: head visible without rd_en
    f_wr_en = 1'b1; f_wr_data = 8'hA5;
    tick();
    f_wr_data = 8'h5A;
    chk("fwft_empty_after_wr", 32'(f_empty), 32'd0);
    chk("fwft_head_a5", 32'(f_rd_data), 32'hA5);
    tick();
    f_wr_en = 1'b0;
    chk("fwft_head_kept", 32'(f_rd_data), 32'hA5);
    chk("fwft_count2", 32'(f_count), 32'd2);
    f_rd_en = 1'b1;
    tick();
    chk("fwft_head_5a", 32'(f_rd_data), 32'h5A);
    chk("fwft_count1", 32'(f_count), 32'd1);
    tick();
    f_rd_en = 1'b0;
    chk("fwft_empty_end", 32'(f_empty), 32'd1);

    // Fill and drain in order
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      if (i == 7) chk("fill_not_full_at7", 32'(full), 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count8", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) pop_chk("drain_order", 8'(i));
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count0", 32'(count), 32'd0);

    // Simultaneous write+read at full
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    wr_en = 1'b1; wr_data = 8'hEE; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("full_wr_rd_head", 32'(rd_data), 32'h10);
    chk("full_wr_rd_count7", 32'(count), 32'd7);
    chk("full_wr_rd_full0", 32'(full), 32'd0);
    chk("full_wr_rd_ovf", 32'(ovf), 32'd0);
    for (int i = 1; i < 8; i++) pop_chk("full_wr_rd_drain", 8'h10 + 8'(i));
    chk("full_wr_rd_empty", 32'(empty), 32'd1);

    // Read at empty: rejected, output held
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("underflow_flag", 32'(unf), 32'(ErrEn));
    chk("underflow_rd_held", 32'(rd_data), 32'h17);
    chk("underflow_count", 32'(count), 32'd0);

    // Steady streaming at count 3 across pointer wrap
    push(8'h20); push(8'h21); push(8'h22);
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1; wr_data = 8'h23 + 8'(k); rd_en = 1'b1;
      tick();
      chk("stream_data", 32'(rd_data), 32'h20 + 32'(k));
      chk("stream_count3", 32'(count), 32'd3);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    pop_chk("stream_tail0", 8'h34);
    pop_chk("stream_tail1", 8'h35);
    pop_chk("stream_tail2", 8'h36);
    chk("stream_empty", 32'(empty), 32'd1);

    // Almost-full / almost-empty thresholds
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    chk("af_count5", 32'(count), 32'd5);
    chk("af_off_at5", 32'(afull), 32'd0);
    wr_en = 1'b1; wr_data = 8'h35;
    #1;
    chk("af_no_comb_path", 32'(afull), 32'd0);
    tick();
    wr_en = 1'b0;
    chk("af_on_at6", 32'(afull), 32'd1);
    chk("af_count6", 32'(count), 32'd6);
    for (int i = 0; i < 4; i++) pop_chk("ae_drain", 8'h30 + 8'(i));
    chk("ae_off_at2", 32'(aempty), 32'd0);
    pop_chk("ae_drain4", 8'h34);
    chk("ae_on_at1", 32'(aempty), 32'd1);
    pop_chk("ae_drain5", 8'h35);

    // Clear beats a same-cycle write
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    chk("clr_count4", 32'(count), 32'd4);
    clear = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    tick();
    clear = 1'b0; wr_en = 1'b0;
    chk("clr_count0", 32'(count), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_rd_held", 32'(rd_data), 32'h35);
    chk("clr_unf_cleared", 32'(unf), 32'd0);
    push(8'h50);
    pop_chk("clr_first_after", 8'h50);

    // Reset mid-stream
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("unf_again", 32'(unf), 32'(ErrEn));
    push(8'h60); push(8'h61);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk_reset_state("midrst");
    push(8'h70);
    pop_chk("midrst_first_wr", 8'h70);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
